// File: rtl/psp_mem_pkg.sv
// Shared definitions for the main-memory port arbiters of the psp top level.
package psp_mem_pkg;

    localparam int PSP_ADDR_W = 32;
    localparam int PSP_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Index width for a requester count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request bit above last_i, wrapping.
module rr_picker
    import psp_mem_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Offsets 1..N_REQ put the last winner at the lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_i) + k) % N_REQ);
            if (!grant_o && req_i[cand]) begin
                grant_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between N_REQ requesters,
// one transaction in flight at a time with a fixed memory read latency.
module mem_arbiter
    import psp_mem_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = PSP_ADDR_W,
    parameter int DATA_W      = PSP_DATA_W,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_data_i,
    output logic                    mem_data_en,
    output logic                    mem_write_en,
    input  logic [DATA_W-1:0]       mem_data_o
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    arb_state_t       state_q;
    logic [IDX_W-1:0] rr_last_q;
    logic [IDX_W-1:0] owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic             mem_en_q;
    logic             mem_we_q;
    logic [N_REQ-1:0] resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;

    logic             pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [N_REQ-1:0] owner_onehot;
    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_i   (req_valid),
        .last_i  (rr_last_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign addr_arr[gi]     = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi]    = req_wdata[gi*DATA_W +: DATA_W];
        assign pick_onehot[gi]  = (pick_idx == IDX_W'(gi));
        assign owner_onehot[gi] = (owner_q == IDX_W'(gi));
    end

    // The accept pulse must land in the sampling cycle, so it is the only
    // output decoded from live inputs; reset masks it while asserted.
    assign req_ready = (state_q == IDLE && pick_grant && !reset) ? pick_onehot : '0;

    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_i   = mem_wdata_q;
    assign mem_data_en  = mem_en_q;
    assign mem_write_en = mem_we_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_last_q    <= IDX_W'(N_REQ - 1);
            owner_q      <= '0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Memory registers double as the latched request fields.
                    if (pick_grant) begin
                        owner_q     <= pick_idx;
                        rr_last_q   <= pick_idx;
                        mem_addr_q  <= addr_arr[pick_idx];
                        mem_wdata_q <= wdata_arr[pick_idx];
                        mem_we_q    <= req_we[pick_idx];
                        mem_en_q    <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_we_q    <= 1'b0;
                    mem_en_q    <= 1'b0;
                    cnt_q       <= CNT_W'(MEM_LATENCY);
                    state_q     <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        resp_rdata_q <= mem_data_o;
                        resp_valid_q <= owner_onehot;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    a_resp_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(resp_valid));
    a_no_overlap:   assert property (@(posedge clk) disable iff (reset) !(|req_ready && |resp_valid));
    a_en_in_issue:  assert property (@(posedge clk) disable iff (reset) mem_data_en |-> state_q == ISSUE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one MEM_LATENCY=1 instance (a) and one
// MEM_LATENCY=3 instance (b), each with a small latency-accurate memory model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  rv_a = '0, we_a = '0, rdy_a, rsp_a;
    logic [63:0] addr_a = '0, wd_a = '0;
    logic [31:0] rdata_a, maddr_a, mwd_a, mdo_a;
    logic        men_a, mwe_a;

    logic [1:0]  rv_b = '0, we_b = '0, rdy_b, rsp_b;
    logic [63:0] addr_b = '0, wd_b = '0;
    logic [31:0] rdata_b, maddr_b, mwd_b, mdo_b;
    logic        men_b, mwe_b;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] pipe_b [3];

    logic [31:0] lone_addr [3] = '{32'h40, 32'h80, 32'h200};
    logic [31:0] lone_data [3] = '{32'hDEADBEEF, 32'h12345678, 32'hB1B10200};

    mem_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut_a (
        .clk(clk), .reset(rst),
        .req_valid(rv_a), .req_we(we_a), .req_addr(addr_a), .req_wdata(wd_a),
        .req_ready(rdy_a), .resp_valid(rsp_a), .resp_rdata(rdata_a),
        .mem_addr(maddr_a), .mem_data_i(mwd_a), .mem_data_en(men_a),
        .mem_write_en(mwe_a), .mem_data_o(mdo_a)
    );

    mem_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_dut_b (
        .clk(clk), .reset(rst),
        .req_valid(rv_b), .req_we(we_b), .req_addr(addr_b), .req_wdata(wd_b),
        .req_ready(rdy_b), .resp_valid(rsp_b), .resp_rdata(rdata_b),
        .mem_addr(maddr_b), .mem_data_i(mwd_b), .mem_data_en(men_b),
        .mem_write_en(mwe_b), .mem_data_o(mdo_b)
    );

    // Memory a: data valid one cycle after the enable edge, zero otherwise.
    always @(posedge clk) begin
        if (rst) begin
            mem_a[16]  <= 32'hDEADBEEF;
            mem_a[64]  <= 32'hA0A00100;
            mem_a[128] <= 32'hB1B10200;
            mdo_a      <= '0;
        end else begin
            if (men_a && mwe_a) mem_a[maddr_a[9:2]] <= mwd_a;
            mdo_a <= men_a ? mem_a[maddr_a[9:2]] : 32'h0;
        end
    end

    // Memory b: data valid for exactly one cycle, three cycles after the enable edge.
    always @(posedge clk) begin
        if (rst) begin
            mem_b[16]  <= 32'hDEADBEEF;
            for (int k = 0; k < 3; k++) pipe_b[k] <= '0;
        end else begin
            if (men_b && mwe_b) mem_b[maddr_b[9:2]] <= mwd_b;
            pipe_b[0] <= men_b ? mem_b[maddr_b[9:2]] : 32'h0;
            for (int k = 1; k < 3; k++) pipe_b[k] <= pipe_b[k-1];
        end
    end
    assign mdo_b = pipe_b[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic wait_accept(input string tag, input bit use_b, input logic [1:0] exp,
                               output int acc_cyc);
        int n = 0;
        @(negedge clk);
        while (((use_b ? rdy_b : rdy_a) == 2'b00) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, 64'(use_b ? rdy_b : rdy_a), 64'(exp));
        acc_cyc = cyc;
    endtask

    task automatic issue_check(input string tag, input bit use_b, input logic exp_we,
                               input logic [31:0] exp_addr);
        check_eq({tag, "_men"},  64'(use_b ? men_b : men_a), 64'h1);
        check_eq({tag, "_mwe"},  64'(use_b ? mwe_b : mwe_a), 64'(exp_we));
        check_eq({tag, "_addr"}, 64'(use_b ? maddr_b : maddr_a), 64'(exp_addr));
    endtask

    task automatic wait_resp(input string tag, input bit use_b, input logic [1:0] exp_v,
                             input bit chk_d, input logic [31:0] exp_d,
                             input int acc_cyc, input int exp_lat);
        int n = 0;
        @(negedge clk);
        while (((use_b ? rsp_b : rsp_a) == 2'b00) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_resp"}, 64'(use_b ? rsp_b : rsp_a), 64'(exp_v));
        check_eq({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(exp_lat));
        check_eq({tag, "_rdy_quiet"}, 64'(use_b ? rdy_b : rdy_a), 64'h0);
        check_eq({tag, "_men_quiet"}, 64'(use_b ? men_b : men_a), 64'h0);
        if (chk_d) check_eq({tag, "_rdata"}, 64'(use_b ? rdata_b : rdata_a), 64'(exp_d));
    endtask

    initial begin
        int acc;
        int prev_acc;
        logic [1:0] exp_g;

        // Reset state, with a request already pending to confirm req_ready is masked.
        repeat (2) @(posedge clk);
        #1;
        rv_a = 2'b01;
        addr_a[31:0] = 32'h40;
        @(negedge clk);
        check_eq("rst_ready", 64'(rdy_a), 64'h0);
        check_eq("rst_resp",  64'(rsp_a), 64'h0);
        check_eq("rst_rdata", 64'(rdata_a), 64'h0);
        check_eq("rst_men",   64'(men_a), 64'h0);
        check_eq("rst_mwe",   64'(mwe_a), 64'h0);
        check_eq("rst_maddr", 64'(maddr_a), 64'h0);
        check_eq("rst_mwd",   64'(mwd_a), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read by requester 0.
        wait_accept("rd40", 1'b0, 2'b01, acc);
        @(posedge clk); #1; rv_a = 2'b00;
        @(negedge clk);
        issue_check("rd40", 1'b0, 1'b0, 32'h40);
        wait_resp("rd40", 1'b0, 2'b01, 1'b1, 32'hDEADBEEF, acc, 3);

        // Write then read by requester 1.
        @(posedge clk); #1;
        rv_a = 2'b10; we_a = 2'b10;
        addr_a[63:32] = 32'h80; wd_a[63:32] = 32'h12345678;
        wait_accept("wr80", 1'b0, 2'b10, acc);
        @(posedge clk); #1; rv_a = 2'b00; we_a = 2'b00;
        @(negedge clk);
        issue_check("wr80", 1'b0, 1'b1, 32'h80);
        check_eq("wr80_wdata", 64'(mwd_a), 64'h12345678);
        wait_resp("wr80", 1'b0, 2'b10, 1'b0, 32'h0, acc, 3);
        check_eq("wr80_mwe_after", 64'(mwe_a), 64'h0);
        @(posedge clk); #1; rv_a = 2'b10;
        wait_accept("rd80", 1'b0, 2'b10, acc);
        @(posedge clk); #1; rv_a = 2'b00;
        @(negedge clk);
        issue_check("rd80", 1'b0, 1'b0, 32'h80);
        wait_resp("rd80", 1'b0, 2'b10, 1'b1, 32'h12345678, acc, 3);

        // Contention: both requesters held high for four transactions.
        @(posedge clk); #1;
        rv_a = 2'b11;
        addr_a = {32'h200, 32'h100};
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_accept($sformatf("ct%0d", i), 1'b0, exp_g, acc);
            if (i > 0) check_eq($sformatf("ct%0d_gap", i), 64'(acc - prev_acc), 64'd4);
            prev_acc = acc;
            @(posedge clk); #1;
            if (i == 3) rv_a = 2'b00;
            wait_resp($sformatf("ct%0d", i), 1'b0, exp_g, 1'b1,
                      (i % 2 == 0) ? 32'hA0A00100 : 32'hB1B10200, acc, 3);
        end

        // Lone requester 1, three back-to-back reads with new fields after each accept.
        @(posedge clk); #1;
        rv_a = 2'b10;
        addr_a[63:32] = lone_addr[0];
        for (int i = 0; i < 3; i++) begin
            wait_accept($sformatf("lone%0d", i), 1'b0, 2'b10, acc);
            if (i > 0) check_eq($sformatf("lone%0d_gap", i), 64'(acc - prev_acc), 64'd4);
            prev_acc = acc;
            @(posedge clk); #1;
            if (i < 2) addr_a[63:32] = lone_addr[i+1];
            else rv_a = 2'b00;
            wait_resp($sformatf("lone%0d", i), 1'b0, 2'b10, 1'b1, lone_data[i], acc, 3);
        end

        // MEM_LATENCY=3 instance.
        @(posedge clk); #1;
        rv_b = 2'b01;
        addr_b[31:0] = 32'h40;
        wait_accept("l3", 1'b1, 2'b01, acc);
        @(posedge clk); #1; rv_b = 2'b00;
        @(negedge clk);
        issue_check("l3", 1'b1, 1'b0, 32'h40);
        wait_resp("l3", 1'b1, 2'b01, 1'b1, 32'hDEADBEEF, acc, 5);

        // Reset during WAIT: no response escapes, requester 0 wins first afterwards.
        @(posedge clk); #1;
        rv_a = 2'b01;
        addr_a = {32'h200, 32'h40};
        wait_accept("rw_pre", 1'b0, 2'b01, acc);
        @(posedge clk); #1; rv_a = 2'b11;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("rw_ready", 64'(rdy_a), 64'h0);
        check_eq("rw_resp",  64'(rsp_a), 64'h0);
        check_eq("rw_men",   64'(men_a), 64'h0);
        check_eq("rw_rdata", 64'(rdata_a), 64'h0);
        @(negedge clk);
        check_eq("rw_resp_hold", 64'(rsp_a), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_accept("rw_post0", 1'b0, 2'b01, acc);
        @(posedge clk); #1; rv_a = 2'b10;
        wait_resp("rw_post0", 1'b0, 2'b01, 1'b1, 32'hDEADBEEF, acc, 3);
        wait_accept("rw_post1", 1'b0, 2'b10, acc);
        @(posedge clk); #1; rv_a = 2'b00;
        wait_resp("rw_post1", 1'b0, 2'b10, 1'b1, 32'hB1B10200, acc, 3);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
